// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor_if : PLL-side and status signals of the lock supervisor
// Revision: 1.0
// ============================================================================
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  // master: the supervisor itself; slave: PLL wrapper / pixel-domain logic
  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_ready,
    output lock_lost,
    output retry_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_ready,
    input  lock_lost,
    input  retry_count
  );
endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor : PLL reset sequencer and lock qualifier (refclk domain)
// Define PLL_SUP_TIMEOUT_EN to enable the lock-acquisition timeout and retry.
// Revision: 1.0
// ============================================================================
module pll_lock_supervisor #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_FILTER    = 1024,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire                   refclk,
  input  wire                   rst_n,
  pll_lock_supervisor_if.master sup
);

  localparam logic [1:0] ST_RESET     = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_FILTER    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int FLT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);

  generate
    if (RST_CYCLES < 1 || LOCK_FILTER < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("pll_lock_supervisor: parameter out of range");
    end
  endgenerate

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             locked_s;
  logic [1:0]       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic             retry_evt;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_ready_q, sys_ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [7:0]       retry_count_q, retry_count_d;

`ifdef PLL_SUP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // pll_locked is asynchronous to refclk; only the second stage is consumed
  always_comb begin
    sync1_d = sup.pll_locked;
    sync2_d = sync1_q;
  end

  assign locked_s = sync2_q;

  // State and counter register
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      state_q       <= ST_RESET;
      rst_cnt_q     <= '0;
      filt_cnt_q    <= '0;
      pll_rst_q     <= 1'b1;
      sys_ready_q   <= 1'b0;
      lock_lost_q   <= 1'b0;
      retry_count_q <= 8'd0;
`ifdef PLL_SUP_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      filt_cnt_q    <= filt_cnt_d;
      pll_rst_q     <= pll_rst_d;
      sys_ready_q   <= sys_ready_d;
      lock_lost_q   <= lock_lost_d;
      retry_count_q <= retry_count_d;
`ifdef PLL_SUP_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    filt_cnt_d = filt_cnt_q;
    retry_evt  = 1'b0;
`ifdef PLL_SUP_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      ST_RESET: begin
        filt_cnt_d = '0;
`ifdef PLL_SUP_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d    = ST_FILTER;
          filt_cnt_d = '0;
        end
      end
      ST_FILTER: begin
        if (!locked_s) begin
          state_d    = ST_WAIT_LOCK;
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FLT_LAST) begin
          state_d = ST_RUN;
        end else begin
          filt_cnt_d = filt_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d   = ST_RESET;
          retry_evt = 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase
`ifdef PLL_SUP_TIMEOUT_EN
    // Evaluated last so an expiring timeout overrides a completing filter
    if (state_q == ST_WAIT_LOCK || state_q == ST_FILTER) begin
      if (to_cnt_q == TO_LAST) begin
        state_d   = ST_RESET;
        retry_evt = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  // Outputs are decoded from the next state so they switch with the FSM
  always_comb begin
    pll_rst_d     = (state_d == ST_RESET);
    sys_ready_d   = (state_d == ST_RUN);
    lock_lost_d   = (state_q == ST_RUN) && (state_d == ST_RESET);
    retry_count_d = retry_count_q;
    if (retry_evt && (retry_count_q != 8'hFF)) begin
      retry_count_d = retry_count_q + 8'd1;
    end
  end

  assign sup.pll_rst     = pll_rst_q;
  assign sup.sys_ready   = sys_ready_q;
  assign sup.lock_lost   = lock_lost_q;
  assign sup.retry_count = retry_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_supervisor : directed scenarios plus randomized lock patterns
// Revision: 1.0
// ============================================================================
module tb_pll_lock_supervisor;

  localparam int RST = 4;
  localparam int LF  = 8;
  localparam int TO  = 32;
  localparam int RETRY_PERIOD = RST + TO;

  localparam int M_RESET = 0;
  localparam int M_ACQ   = 1;
  localparam int M_RUN   = 2;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;

  pll_lock_supervisor_if ifc ();

  pll_lock_supervisor #(
    .RST_CYCLES    (RST),
    .LOCK_FILTER   (LF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .sup   (ifc.master)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model: time-stamped phases instead of counters
  typedef struct packed {
    int mode;
    int t_enter;
    int now;
    int run_len;
    int retry;
    bit lost;
  } model_t;

  model_t m_st;
  bit     m_d0, m_d1;

  function automatic model_t model_next(input model_t s, input bit ls);
    model_t n;
    n = s;
    n.now  = s.now + 1;
    n.lost = 1'b0;
    case (s.mode)
      M_RESET: begin
        if (n.now - s.t_enter == RST) begin
          n.mode = M_ACQ; n.t_enter = n.now; n.run_len = 0;
        end
      end
      M_ACQ: begin
`ifdef PLL_SUP_TIMEOUT_EN
        if (n.now - s.t_enter == TO) begin
          n.mode = M_RESET; n.t_enter = n.now;
          n.retry = (s.retry < 255) ? s.retry + 1 : 255;
        end else
`endif
        if (ls) begin
          n.run_len = s.run_len + 1;
          // first high sample only arms the filter; LF more qualify the lock
          if (n.run_len == LF + 1) n.mode = M_RUN;
        end else begin
          n.run_len = 0;
        end
      end
      default: begin
        if (!ls) begin
          n.mode = M_RESET; n.t_enter = n.now; n.lost = 1'b1;
          n.retry = (s.retry < 255) ? s.retry + 1 : 255;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= '{M_RESET, 0, 0, 0, 0, 1'b0};
      m_d0 <= 1'b0;
      m_d1 <= 1'b0;
    end else begin
      m_d0 <= ifc.pll_locked;
      m_d1 <= m_d0;
      m_st <= model_next(m_st, m_d1);
    end
  end

  task automatic do_reset();
    @(negedge refclk);
    rst_n = 1'b0;
    ifc.pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge refclk);
    rst_n = 1'b0;
    ifc.pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    n_checks++;
    if (ifc.pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b expected 1", ifc.pll_rst); end
    n_checks++;
    if (ifc.sys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sys_ready: got %b expected 0", ifc.sys_ready); end
    n_checks++;
    if (ifc.lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost: got %b expected 0", ifc.lock_lost); end
    n_checks++;
    if (ifc.retry_count !== 8'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", ifc.retry_count); end
  endtask

  task automatic test_bring_up();
    int fall_at, rise_at;
    fall_at = -1; rise_at = -1;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge refclk);
      if (fall_at < 0 && ifc.pll_rst === 1'b0) fall_at = cyc;
      if (rise_at < 0 && ifc.sys_ready === 1'b1) rise_at = cyc;
      if (cyc == 9) ifc.pll_locked = 1'b1;   // first sampled on edge 10
    end
    n_checks++;
    if (fall_at != RST) begin n_fail++; $display("FAIL bringup_pll_rst_fall: got %0d expected %0d", fall_at, RST); end
    n_checks++;
    if (rise_at != 10 + 2 + LF) begin n_fail++; $display("FAIL bringup_ready_rise: got %0d expected %0d", rise_at, 10 + 2 + LF); end
    n_checks++;
    if (ifc.pll_rst !== 1'b0 || ifc.sys_ready !== 1'b1) begin
      n_fail++; $display("FAIL bringup_steady: got pll_rst=%b sys_ready=%b expected 0/1", ifc.pll_rst, ifc.sys_ready);
    end
    n_checks++;
    if (ifc.retry_count !== 8'd0) begin n_fail++; $display("FAIL bringup_retry: got %0d expected 0", ifc.retry_count); end
  endtask

  task automatic test_filter_glitch();
    int rise_at;
    rise_at = -1;
    do_reset();
    for (int k = 0; k < 35; k++) begin
      if (k > 0) @(negedge refclk);
      if (rise_at < 0 && ifc.sys_ready === 1'b1) rise_at = cyc;
      if (cyc == 5)  ifc.pll_locked = 1'b1;  // high for edges 6..10
      if (cyc == 10) ifc.pll_locked = 1'b0;  // low on edge 11
      if (cyc == 11) ifc.pll_locked = 1'b1;  // re-asserted from edge 12
    end
    n_checks++;
    if (rise_at != 12 + 2 + LF) begin n_fail++; $display("FAIL glitch_ready_rise: got %0d expected %0d", rise_at, 12 + 2 + LF); end
    n_checks++;
    if (ifc.retry_count !== 8'd0) begin n_fail++; $display("FAIL glitch_retry: got %0d expected 0", ifc.retry_count); end
  endtask

  task automatic test_timeout();
    bit exp_rst;
    int exp_retry;
    do_reset();
    for (int k = 0; k < 3 * RETRY_PERIOD + 6; k++) begin
      if (k > 0) @(negedge refclk);
`ifdef PLL_SUP_TIMEOUT_EN
      exp_rst   = (cyc % RETRY_PERIOD) < RST;
      exp_retry = cyc / RETRY_PERIOD;
`else
      exp_rst   = cyc < RST;
      exp_retry = 0;
`endif
      n_checks++;
      if (ifc.pll_rst !== exp_rst || ifc.retry_count !== 8'(exp_retry)) begin
        n_fail++;
        $display("FAIL timeout_cycle%0d: got pll_rst=%b retry=%0d expected %b/%0d", cyc, ifc.pll_rst, ifc.retry_count, exp_rst, exp_retry);
        break;
      end
    end
  endtask

  task automatic test_lock_loss();
    int c, waited;
    do_reset();
    ifc.pll_locked = 1'b1;
    waited = 0;
    while (ifc.sys_ready !== 1'b1 && waited < 40) begin @(negedge refclk); waited++; end
    // edge 1 samples high, filter can only arm once WAIT_LOCK is reached
    n_checks++;
    if (cyc != RST + 1 + LF) begin n_fail++; $display("FAIL loss_initial_lock: got %0d expected %0d", cyc, RST + 1 + LF); end
    repeat (3) @(negedge refclk);
    c = cyc;
    ifc.pll_locked = 1'b0;
    @(negedge refclk);
    ifc.pll_locked = 1'b1;
    @(negedge refclk);
    n_checks++;
    if (ifc.sys_ready !== 1'b1 || ifc.lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL loss_early: got sys_ready=%b lock_lost=%b expected 1/0", ifc.sys_ready, ifc.lock_lost);
    end
    @(negedge refclk);
    n_checks++;
    if (ifc.lock_lost !== 1'b1 || ifc.sys_ready !== 1'b0 || ifc.pll_rst !== 1'b1) begin
      n_fail++; $display("FAIL loss_edge: got lock_lost=%b sys_ready=%b pll_rst=%b expected 1/0/1", ifc.lock_lost, ifc.sys_ready, ifc.pll_rst);
    end
    n_checks++;
    if (ifc.retry_count !== 8'd1) begin n_fail++; $display("FAIL loss_retry: got %0d expected 1", ifc.retry_count); end
    @(negedge refclk);
    n_checks++;
    if (ifc.lock_lost !== 1'b0) begin n_fail++; $display("FAIL loss_pulse_width: got %b expected 0", ifc.lock_lost); end
    waited = 0;
    while (ifc.sys_ready !== 1'b1 && waited < 40) begin @(negedge refclk); waited++; end
    n_checks++;
    if (cyc != c + 3 + RST + 1 + LF) begin n_fail++; $display("FAIL loss_relock: got %0d expected %0d", cyc, c + 3 + RST + 1 + LF); end
    n_checks++;
    if (ifc.retry_count !== 8'd1) begin n_fail++; $display("FAIL loss_retry_after: got %0d expected 1", ifc.retry_count); end
  endtask

  task automatic test_saturation();
    do_reset();
`ifdef PLL_SUP_TIMEOUT_EN
    for (int k = 0; k < 260 * RETRY_PERIOD + 4; k++) begin
      if (k > 0) @(negedge refclk);
      n_checks++;
      if (ifc.retry_count !== 8'((cyc / RETRY_PERIOD > 255) ? 255 : cyc / RETRY_PERIOD)) begin
        n_fail++; $display("FAIL sat_cycle%0d: got %0d expected %0d", cyc, ifc.retry_count, (cyc / RETRY_PERIOD > 255) ? 255 : cyc / RETRY_PERIOD);
        break;
      end
    end
`else
    ifc.pll_locked = 1'b1;
    for (int i = 0; i < 260; i++) begin
      int waited;
      waited = 0;
      while (ifc.sys_ready !== 1'b1 && waited < 60) begin @(negedge refclk); waited++; end
      if (waited >= 60) begin
        n_checks++; n_fail++; $display("FAIL sat_relock: got no sys_ready expected lock at retry %0d", i);
        break;
      end
      ifc.pll_locked = 1'b0;
      @(negedge refclk);
      ifc.pll_locked = 1'b1;
      repeat (3) @(negedge refclk);
      n_checks++;
      if (ifc.retry_count !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        n_fail++; $display("FAIL sat_loss%0d: got %0d expected %0d", i, ifc.retry_count, (i + 1 > 255) ? 255 : i + 1);
        break;
      end
    end
`endif
    n_checks++;
    if (ifc.retry_count !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d expected 255", ifc.retry_count); end
  endtask

  task automatic test_async_reset();
    int waited;
    do_reset();
    ifc.pll_locked = 1'b1;
    waited = 0;
    while (ifc.sys_ready !== 1'b1 && waited < 40) begin @(negedge refclk); waited++; end
    ifc.pll_locked = 1'b0;
    @(negedge refclk);
    ifc.pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    waited = 0;
    while (ifc.sys_ready !== 1'b1 && waited < 40) begin @(negedge refclk); waited++; end
    n_checks++;
    if (ifc.sys_ready !== 1'b1 || ifc.retry_count !== 8'd1) begin
      n_fail++; $display("FAIL async_precond: got sys_ready=%b retry=%0d expected 1/1", ifc.sys_ready, ifc.retry_count);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifc.sys_ready !== 1'b0 || ifc.pll_rst !== 1'b1) begin
      n_fail++; $display("FAIL async_outputs: got sys_ready=%b pll_rst=%b expected 0/1", ifc.sys_ready, ifc.pll_rst);
    end
    n_checks++;
    if (ifc.retry_count !== 8'd0 || ifc.lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL async_status: got retry=%0d lock_lost=%b expected 0/0", ifc.retry_count, ifc.lock_lost);
    end
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int seg_left;
    bit seg_val;
    bit bad;
    int r;
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      seg_left = 0;
      seg_val  = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (k > 0) @(negedge refclk);
        bad = 1'b0;
        n_checks++;
        if (ifc.pll_rst !== (m_st.mode == M_RESET)) begin
          n_fail++; bad = 1'b1;
          $display("FAIL rand_pll_rst ep%0d cyc%0d: got %b expected %b", ep, cyc, ifc.pll_rst, m_st.mode == M_RESET);
        end
        n_checks++;
        if (ifc.sys_ready !== (m_st.mode == M_RUN)) begin
          n_fail++; bad = 1'b1;
          $display("FAIL rand_sys_ready ep%0d cyc%0d: got %b expected %b", ep, cyc, ifc.sys_ready, m_st.mode == M_RUN);
        end
        n_checks++;
        if (ifc.lock_lost !== m_st.lost) begin
          n_fail++; bad = 1'b1;
          $display("FAIL rand_lock_lost ep%0d cyc%0d: got %b expected %b", ep, cyc, ifc.lock_lost, m_st.lost);
        end
        n_checks++;
        if (ifc.retry_count !== 8'(m_st.retry)) begin
          n_fail++; bad = 1'b1;
          $display("FAIL rand_retry ep%0d cyc%0d: got %0d expected %0d", ep, cyc, ifc.retry_count, m_st.retry);
        end
        if (bad) break;
        if (seg_left == 0) begin
          r = int'($urandom_range(0, 9));
          if (r < 5)      begin seg_val = 1'b1; seg_left = int'($urandom_range(1, 20)); end
          else if (r < 8) begin seg_val = 1'b0; seg_left = int'($urandom_range(1, 4)); end
          else            begin seg_val = 1'b0; seg_left = int'($urandom_range(20, 45)); end
        end
        ifc.pll_locked = seg_val;
        seg_left--;
      end
    end
  endtask

  initial begin
    ifc.pll_locked = 1'b0;
    test_reset();
    test_bring_up();
    test_filter_glitch();
    test_timeout();
    test_lock_loss();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
